// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the elastic pipeline-stage register.
// Optional perf counters in pipe_stage_buf are enabled with PIPE_STAGE_PERF_EN.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int PIPE_CNT_W_DEF = 16;
   localparam int PIPE_WIDTH_DEF = 64;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for the stage performance counters.
// Instantiated by pipe_stage_buf only when PIPE_STAGE_PERF_EN is defined.
module pipe_sat_cnt
   import pipe_pkg::*;
#(
   parameter int CNT_W = PIPE_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Holds at the all-ones value instead of wrapping; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with a two-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall_cycles / flush_count counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH          = PIPE_WIDTH_DEF,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int CNT_W          = PIPE_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   if (WIDTH < 1) begin : g_bad_width
      $error("pipe_stage_buf: WIDTH must be at least 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_buf: CNT_W must be at least 1");
   end

   pipe_state_e      state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign out_data = main_q;

   // in_ready and out_valid are kept as their own flops, updated alongside the
   // state, so neither output has a combinational path from out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         main_q    <= '0;
         skid_q    <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         if (CLEAR_ON_FLUSH) begin
            main_q <= '0;
            skid_q <= '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q    <= in_data;
                  state     <= ONE;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q   <= in_data;
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (out_fire) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               // Skid entry is younger than main, so it moves forward on drain.
               if (out_fire) begin
                  main_q   <= skid_q;
                  state    <= ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic stall_inc;

   assign stall_inc = out_valid & ~out_ready & ~flush;

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_count)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed table, corner sequences and a
// queue-based reference model under random traffic (PIPE_STAGE_PERF_EN optional).
module tb_pipe_stage_buf;

   localparam int W        = 16;
   localparam int TB_CNT_W = 3;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;

   logic         ir_c, ov_c, ir_n, ov_n;
   logic [W-1:0] od_c, od_n;
`ifdef PIPE_STAGE_PERF_EN
   logic [TB_CNT_W-1:0] sc_c, fc_c, sc_n, fc_n;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] mq[$];
   bit           zero_known;
   int           sc_m, fc_m;

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(TB_CNT_W)) dut_c (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir_c),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (ov_c),
      .out_ready (out_ready),
      .out_data  (od_c)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles (sc_c),
      .flush_count  (fc_c)
`endif
   );

   pipe_stage_buf #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(TB_CNT_W)) dut_n (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir_n),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (ov_n),
      .out_ready (out_ready),
      .out_data  (od_n)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles (sc_n),
      .flush_count  (fc_n)
`endif
   );

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         fl;
      logic         eov;
      logic         eir;
      logic         chk;
      logic [W-1:0] ed;
   } vec_t;

   vec_t tbl[12];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of depth two; flush empties it.
   task automatic model_step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      int  sz;
      bit  in_f, out_f;
      sz    = mq.size();
      in_f  = iv && (sz < 2);
      out_f = (sz > 0) && ordy;
      if ((sz > 0) && !ordy && !fl && (sc_m < CNT_MAX)) sc_m++;
      if (fl && (fc_m < CNT_MAX)) fc_m++;
      if (fl) begin
         mq.delete();
         zero_known = 1'b1;
      end else begin
         if (out_f) void'(mq.pop_front());
         if (in_f) begin
            mq.push_back(d);
            zero_known = 1'b0;
         end
      end
   endtask

   task automatic apply_stimulus(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      model_step(iv, d, ordy, fl);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic exp_ov, exp_ir;
      exp_ov = (mq.size() > 0);
      exp_ir = (mq.size() < 2);
      check_output({tag, " out_valid_c"}, {31'd0, ov_c}, {31'd0, exp_ov});
      check_output({tag, " out_valid_n"}, {31'd0, ov_n}, {31'd0, exp_ov});
      check_output({tag, " in_ready_c"}, {31'd0, ir_c}, {31'd0, exp_ir});
      check_output({tag, " in_ready_n"}, {31'd0, ir_n}, {31'd0, exp_ir});
      if (exp_ov) begin
         check_output({tag, " out_data_c"}, {16'd0, od_c}, {16'd0, mq[0]});
         check_output({tag, " out_data_n"}, {16'd0, od_n}, {16'd0, mq[0]});
      end else if (zero_known) begin
         check_output({tag, " out_data_c zero"}, {16'd0, od_c}, 32'd0);
      end
`ifdef PIPE_STAGE_PERF_EN
      check_output({tag, " stall_cycles"}, {29'd0, sc_c}, sc_m);
      check_output({tag, " flush_count"}, {29'd0, fc_c}, fc_m);
`endif
   endtask

   task automatic reset_dut();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      rst       = 1'b1;
      mq.delete();
      zero_known = 1'b1;
      sc_m = 0;
      fc_m = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1};
      tbl[1]  = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1};
      tbl[2]  = '{1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1};
      tbl[3]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00B2};
      tbl[4]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00C3};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      tbl[6]  = '{1'b1, 16'h00D4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00D4};
      tbl[7]  = '{1'b1, 16'h00E5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00D4};
      tbl[8]  = '{1'b1, 16'h00F6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
      tbl[10] = '{1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0055};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};

      $display("[TB] reset state");
      reset_dut();
      check_output("reset out_valid", {31'd0, ov_c}, 32'd0);
      check_output("reset in_ready", {31'd0, ir_c}, 32'd1);
      check_output("reset out_data", {16'd0, od_c}, 32'd0);
      check_output("reset out_data_n", {16'd0, od_n}, 32'd0);

      $display("[TB] directed table: backpressure and flush");
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         check_output($sformatf("tbl%0d out_valid", i), {31'd0, ov_c}, {31'd0, tbl[i].eov});
         check_output($sformatf("tbl%0d in_ready", i), {31'd0, ir_c}, {31'd0, tbl[i].eir});
         check_output($sformatf("tbl%0d out_valid_n", i), {31'd0, ov_n}, {31'd0, tbl[i].eov});
         check_output($sformatf("tbl%0d in_ready_n", i), {31'd0, ir_n}, {31'd0, tbl[i].eir});
         if (tbl[i].chk)
            check_output($sformatf("tbl%0d out_data", i), {16'd0, od_c}, {16'd0, tbl[i].ed});
      end

      $display("[TB] streaming");
      reset_dut();
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus(1'b1, W'(i), 1'b1, 1'b0);
         check_output($sformatf("stream%0d out_valid", i), {31'd0, ov_c}, 32'd1);
         check_output($sformatf("stream%0d in_ready", i), {31'd0, ir_c}, 32'd1);
         check_output($sformatf("stream%0d out_data", i), {16'd0, od_c}, i);
      end
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("stream drain out_valid", {31'd0, ov_c}, 32'd0);

      $display("[TB] flush with retention");
      reset_dut();
      apply_stimulus(1'b1, 16'h0005, 1'b0, 1'b0);
      check_output("retain pre out_data_n", {16'd0, od_n}, 32'h5);
      apply_stimulus(1'b1, 16'h0009, 1'b0, 1'b1);
      check_output("retain out_valid_n", {31'd0, ov_n}, 32'd0);
      check_output("retain out_data_n", {16'd0, od_n}, 32'h5);
      check_output("retain clear out_data_c", {16'd0, od_c}, 32'd0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("retain post in_ready_n", {31'd0, ir_n}, 32'd1);

      $display("[TB] asynchronous reset mid-transfer");
      apply_stimulus(1'b1, 16'h0AAA, 1'b0, 1'b0);
      apply_stimulus(1'b1, 16'h0BBB, 1'b0, 1'b0);
      check_output("pre-reset in_ready", {31'd0, ir_c}, 32'd0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_output("async out_valid", {31'd0, ov_c}, 32'd0);
      check_output("async in_ready", {31'd0, ir_c}, 32'd1);
      check_output("async out_data", {16'd0, od_c}, 32'd0);
      check_output("async out_data_n", {16'd0, od_n}, 32'd0);
      reset_dut();

`ifdef PIPE_STAGE_PERF_EN
      $display("[TB] perf counters");
      reset_dut();
      check_output("perf reset stall", {29'd0, sc_c}, 32'd0);
      check_output("perf reset flush", {29'd0, fc_c}, 32'd0);
      apply_stimulus(1'b1, 16'h0011, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("perf stall5", {29'd0, sc_c}, 32'd5);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("perf flush2", {29'd0, fc_c}, 32'd2);
      check_output("perf stall after flush", {29'd0, sc_c}, 32'd5);
      apply_stimulus(1'b1, 16'h0022, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("perf stall sat", {29'd0, sc_c}, 32'd7);
      check_output("perf stall sat_n", {29'd0, sc_n}, 32'd7);
      check_output("perf flush_n", {29'd0, fc_n}, 32'd2);
`endif

      $display("[TB] random traffic against reference model");
      reset_dut();
      check_model("rnd reset");
      for (int i = 0; i < 1500; i++) begin
         apply_stimulus(($urandom % 4) != 0,
                        W'($urandom),
                        ($urandom % 3) != 0,
                        ($urandom % 32) == 0);
         check_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
